// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter
// Shift-register phase sequencer. It runs either as a one-hot ring or as a
// Johnson (twisted-ring) counter and can shift in either direction. It also
// provides parallel load, a wrap pulse on re-entering HOME, and illegal-state
// detection. AUTOCORRECT sets whether an illegal state is pulled back to HOME.

module ring_johnson_counter #(
    parameter int N           = 4,
    parameter bit AUTOCORRECT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic         dir,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] Q,
    output logic         wrap,
    output logic         err
);

    localparam logic [N-1:0] HOME  = N'(1);
    localparam logic [N-2:0] T_ONE = (N-1)'(1);

    logic [N-1:0] shifted;
    logic [N-2:0] transitions;
    logic         ring_legal;
    logic         johnson_legal;
    logic         legal;

    // Legality of the current state. In ring mode the state must be exactly
    // one-hot. In Johnson mode it may have at most one boundary between
    // adjacent bits. Clearing the lowest set bit (x & (x-1)) and getting zero
    // tests for "at most one bit set".
    always_comb begin
        transitions   = Q[N-2:0] ^ Q[N-1:1];
        ring_legal    = (Q != '0) && ((Q & (Q - HOME)) == '0);
        johnson_legal = ((transitions & (transitions - T_ONE)) == '0);
        legal         = mode ? johnson_legal : ring_legal;
        err           = ~legal;
    end

    // Candidate next state for a normal step, chosen by mode and direction.
    always_comb begin
        shifted = Q;
        case ({mode, dir})
            2'b00:   shifted = {Q[0], Q[N-1:1]};
            2'b01:   shifted = {Q[N-2:0], Q[N-1]};
            2'b10:   shifted = {~Q[0], Q[N-1:1]};
            2'b11:   shifted = {Q[N-2:0], ~Q[N-1]};
            default: shifted = Q;
        endcase
    end

    // State register. Priority is load, then step, then hold. wrap marks only
    // a normal step landing on HOME; a forced return to HOME does not count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q    <= HOME;
            wrap <= 1'b0;
        end else if (load) begin
            Q    <= load_val;
            wrap <= 1'b0;
        end else if (en) begin
            if (AUTOCORRECT && !legal) begin
                Q    <= HOME;
                wrap <= 1'b0;
            end else begin
                Q    <= shifted;
                wrap <= (shifted == HOME);
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed testbench for ring_johnson_counter. It drives an autocorrecting
// N=4 instance, a non-correcting N=4 instance and an N=2 instance from the
// same control inputs.

module tb_ring_johnson_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'b0000;
    logic [3:0] q_ac, q_nc;
    logic       wrap_ac, wrap_nc, err_ac, err_nc;
    logic [1:0] q2;
    logic       wrap2, err2;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ring_johnson_counter #(.N(4), .AUTOCORRECT(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val), .Q(q_ac), .wrap(wrap_ac), .err(err_ac)
    );

    ring_johnson_counter #(.N(4), .AUTOCORRECT(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val), .Q(q_nc), .wrap(wrap_nc), .err(err_nc)
    );

    ring_johnson_counter #(.N(2), .AUTOCORRECT(1'b1)) dut_n2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val[1:0]), .Q(q2), .wrap(wrap2), .err(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (q_ac !== 4'b0001 || wrap_ac !== 1'b0 || err_ac !== 1'b0) begin
            fails++;
            $display("FAIL reset: Q=%b wrap=%b err=%b expected Q=0001 wrap=0 err=0", q_ac, wrap_ac, err_ac);
        end
        tick();
        tests_run++;
        if (q_ac !== 4'b0001 || wrap_ac !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: Q=%b wrap=%b expected Q=0001 wrap=0", q_ac, wrap_ac);
        end
    endtask

    task automatic test_ring_seq();
        logic [3:0] exp_q[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        do_reset();
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (q_ac !== exp_q[i%4] || wrap_ac !== (i%4 == 3) || err_ac !== 1'b0) begin
                fails++;
                $display("FAIL ring_seq step %0d: Q=%b wrap=%b err=%b expected Q=%b wrap=%b err=0",
                         i, q_ac, wrap_ac, err_ac, exp_q[i%4], (i%4 == 3));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_johnson_seq();
        logic [3:0] exp_r[8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                                 4'b1111, 4'b0111, 4'b0011, 4'b0001};
        logic [3:0] exp_l[8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                 4'b1100, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        mode = 1'b1; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (q_ac !== exp_r[i] || wrap_ac !== (i == 7) || err_ac !== 1'b0) begin
                fails++;
                $display("FAIL johnson_right step %0d: Q=%b wrap=%b err=%b expected Q=%b wrap=%b err=0",
                         i, q_ac, wrap_ac, err_ac, exp_r[i], (i == 7));
            end
        end
        dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (q_ac !== exp_l[i] || wrap_ac !== (i == 7) || err_ac !== 1'b0) begin
                fails++;
                $display("FAIL johnson_left step %0d: Q=%b wrap=%b err=%b expected Q=%b wrap=%b err=0",
                         i, q_ac, wrap_ac, err_ac, exp_l[i], (i == 7));
            end
        end
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_autocorrect();
        do_reset();
        mode = 1'b0; dir = 1'b0;
        load = 1'b1; load_val = 4'b0101;
        tick();
        load = 1'b0;
        tests_run++;
        if (q_ac !== 4'b0101 || err_ac !== 1'b1 || err_nc !== 1'b1) begin
            fails++;
            $display("FAIL illegal_load: Q=%b err=%b err_nc=%b expected Q=0101 err=1 err_nc=1", q_ac, err_ac, err_nc);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        tests_run++;
        if (q_ac !== 4'b0001 || wrap_ac !== 1'b0 || err_ac !== 1'b0) begin
            fails++;
            $display("FAIL autocorrect: Q=%b wrap=%b err=%b expected Q=0001 wrap=0 err=0", q_ac, wrap_ac, err_ac);
        end
        tests_run++;
        if (q_nc !== 4'b1010 || err_nc !== 1'b1 || wrap_nc !== 1'b0) begin
            fails++;
            $display("FAIL no_autocorrect: Q=%b err=%b wrap=%b expected Q=1010 err=1 wrap=0", q_nc, err_nc, wrap_nc);
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode = 1'b1; dir = 1'b0;
        load = 1'b1; load_val = 4'b0011;
        tick();
        load = 1'b0;
        tests_run++;
        if (q_ac !== 4'b0011 || err_ac !== 1'b0) begin
            fails++;
            $display("FAIL johnson_legal: Q=%b err=%b expected Q=0011 err=0", q_ac, err_ac);
        end
        mode = 1'b0;
        #1;
        tests_run++;
        if (err_ac !== 1'b1 || q_ac !== 4'b0011) begin
            fails++;
            $display("FAIL mode_switch_err: Q=%b err=%b expected Q=0011 err=1", q_ac, err_ac);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        tests_run++;
        if (q_ac !== 4'b0001 || err_ac !== 1'b0 || wrap_ac !== 1'b0) begin
            fails++;
            $display("FAIL mode_switch_fix: Q=%b err=%b wrap=%b expected Q=0001 err=0 wrap=0", q_ac, err_ac, wrap_ac);
        end
        tests_run++;
        if (q_nc !== 4'b1001) begin
            fails++;
            $display("FAIL mode_switch_nc: Q=%b expected Q=1001", q_nc);
        end
    endtask

    task automatic test_load_priority_hold();
        do_reset();
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        tick(); tick(); tick();
        tests_run++;
        if (q_ac !== 4'b0010) begin
            fails++;
            $display("FAIL pre_load: Q=%b expected Q=0010", q_ac);
        end
        load = 1'b1; load_val = 4'b0100;
        tick();
        load = 1'b0; en = 1'b0;
        tests_run++;
        if (q_ac !== 4'b0100 || wrap_ac !== 1'b0) begin
            fails++;
            $display("FAIL load_priority: Q=%b wrap=%b expected Q=0100 wrap=0", q_ac, wrap_ac);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (q_ac !== 4'b0100 || wrap_ac !== 1'b0) begin
                fails++;
                $display("FAIL hold cycle %0d: Q=%b wrap=%b expected Q=0100 wrap=0", i, q_ac, wrap_ac);
            end
        end
    endtask

    task automatic test_hold_clears_wrap();
        do_reset();
        mode = 1'b0; dir = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (q_ac !== 4'b0001 || wrap_ac !== 1'b1) begin
            fails++;
            $display("FAIL ring_left_wrap: Q=%b wrap=%b expected Q=0001 wrap=1", q_ac, wrap_ac);
        end
        en = 1'b0;
        tick();
        tests_run++;
        if (q_ac !== 4'b0001 || wrap_ac !== 1'b0) begin
            fails++;
            $display("FAIL hold_wrap_clear: Q=%b wrap=%b expected Q=0001 wrap=0", q_ac, wrap_ac);
        end
        dir = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        tick(); tick();
        tests_run++;
        if (q_ac !== 4'b0100) begin
            fails++;
            $display("FAIL pre_async: Q=%b expected Q=0100", q_ac);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (q_ac !== 4'b0001 || wrap_ac !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: Q=%b wrap=%b expected Q=0001 wrap=0", q_ac, wrap_ac);
        end
        tick();
        rst = 1'b0;
        tests_run++;
        if (q_ac !== 4'b0001) begin
            fails++;
            $display("FAIL reset_overrides_en: Q=%b expected Q=0001", q_ac);
        end
        tick();
        tests_run++;
        if (q_ac !== 4'b1000 || wrap_ac !== 1'b0) begin
            fails++;
            $display("FAIL restart: Q=%b wrap=%b expected Q=1000 wrap=0", q_ac, wrap_ac);
        end
        en = 1'b0;
    endtask

    task automatic test_n2();
        logic [1:0] exp_j[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
        do_reset();
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        tick();
        tests_run++;
        if (q2 !== 2'b10 || wrap2 !== 1'b0) begin
            fails++;
            $display("FAIL n2_ring_a: Q=%b wrap=%b expected Q=10 wrap=0", q2, wrap2);
        end
        tick();
        tests_run++;
        if (q2 !== 2'b01 || wrap2 !== 1'b1) begin
            fails++;
            $display("FAIL n2_ring_b: Q=%b wrap=%b expected Q=01 wrap=1", q2, wrap2);
        end
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (q2 !== exp_j[i] || wrap2 !== (i == 3) || err2 !== 1'b0) begin
                fails++;
                $display("FAIL n2_johnson step %0d: Q=%b wrap=%b err=%b expected Q=%b wrap=%b err=0",
                         i, q2, wrap2, err2, exp_j[i], (i == 3));
            end
        end
        en = 1'b0; mode = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_ring_seq();
        test_johnson_seq();
        test_autocorrect();
        test_mode_switch();
        test_load_priority_hold();
        test_hold_clears_wrap();
        test_async_reset();
        test_n2();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
